genius_seq_engine: RTL and testbench

Parametrised game engine for the Genius memory game: it generates a pseudo-random symbol sequence, plays back a growing prefix with timed lamp output, and checks the player's button presses against it. It supports N buttons, a configurable maximum length, an input timeout and explicit win/lose reporting. It sits between the debounced board buttons and the seven-segment/LED display decoders.

---
 rtl/genius_pkg.sv | 20 ++
 rtl/genius_lfsr16.sv | 11 +
 rtl/genius_seq_engine.sv | 151 +++++++++++++++
 tb/tb_genius_seq_engine.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// genius_pkg: state encoding, LFSR taps and width helpers shared by the Genius engine
package genius_pkg;
  typedef enum logic [2:0] {IDLE, GEN, SHOW, GAP, WAIT_IN, NEXT_LVL, WIN, LOSE} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int sym_width(input int n);
    return clog2(n) < 1 ? 1 : clog2(n);
  endfunction
  function automatic int lvl_width(input int m);
    return clog2(m);
  endfunction
  function automatic int cnt_width(input int a, input int b);
    return clog2(a > b ? a : b) < 1 ? 1 : clog2(a > b ? a : b);
  endfunction
endpackage

// File: rtl/genius_lfsr16.sv
// genius_lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
module genius_lfsr16 import genius_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] q
);
  always_ff @(posedge clock)
    q <= !reset ? SEED : {q[14:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/genius_seq_engine.sv
// genius_seq_engine: Genius memory-game sequencer with timed playback, press checking and win/lose pulses
module genius_seq_engine import genius_pkg::*; #(
  parameter int          N_BTN          = 3,
  parameter int          MAX_LEN        = 16,
  parameter int          SHOW_CYCLES    = 4,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [15:0] SEED           = 16'hACE1,
  localparam int         SW             = sym_width(N_BTN),
  localparam int         LW             = lvl_width(MAX_LEN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] leds,
  output logic [SW-1:0]    symbol_out,
  output logic             symbol_valid,
  output logic [LW-1:0]    level,
  output logic [LW-1:0]    step,
  output logic             busy,
  output logic             win,
  output logic             lose
);
  localparam int CW = cnt_width(SHOW_CYCLES, TIMEOUT_CYCLES);
  state_t state;
  logic [15:0] q;
  logic unused_q;
  logic [SW-1:0] raw, sym;
  logic [SW-1:0] seq [MAX_LEN];
  logic [LW-1:0] idx, step_n;
  logic [CW-1:0] cnt;
  logic [N_BTN-1:0] btn_q, edge_r;
  logic show_done, last_step, timed_out;
  function automatic logic [N_BTN-1:0] lamp(input logic [SW-1:0] s);
    return N_BTN'(1) << s;
  endfunction
  genius_lfsr16 #(.SEED(SEED)) u_lfsr (.clock(clock), .reset(reset), .q(q));
  always_comb begin
    unused_q = ^q[15:SW];
    raw = q[SW-1:0];
    sym = {1'b0, raw} >= (SW+1)'(N_BTN) ? raw - SW'(N_BTN) : raw;
    step_n = step + LW'(1);
    show_done = cnt == CW'(SHOW_CYCLES - 1);
    timed_out = cnt == CW'(TIMEOUT_CYCLES - 1);
    last_step = step == level;
  end
  always_ff @(posedge clock)
    if (state == GEN) seq[idx] <= sym;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      btn_q <= '0;
      edge_r <= '0;
      leds <= '0;
      symbol_out <= '0;
      symbol_valid <= 1'b0;
      level <= '0;
      step <= '0;
      busy <= 1'b0;
      win <= 1'b0;
      lose <= 1'b0;
    end else begin
      btn_q <= btn;
      edge_r <= btn & ~btn_q;
      win <= 1'b0;
      lose <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= GEN;
          level <= '0;
          step <= '0;
          idx <= '0;
          cnt <= '0;
          busy <= 1'b1;
        end
        GEN: begin
          idx <= idx + LW'(1);
          if (idx == LW'(MAX_LEN - 1)) begin
            state <= SHOW;
            step <= '0;
            cnt <= '0;
            symbol_out <= seq[0];
            symbol_valid <= 1'b1;
            leds <= lamp(seq[0]);
          end
        end
        SHOW: if (show_done) begin
          state <= GAP;
          cnt <= '0;
          leds <= '0;
          symbol_valid <= 1'b0;
        end else cnt <= cnt + CW'(1);
        GAP: if (show_done) begin
          cnt <= '0;
          if (last_step) begin
            state <= WAIT_IN;
            step <= '0;
          end else begin
            state <= SHOW;
            step <= step_n;
            symbol_out <= seq[step_n];
            symbol_valid <= 1'b1;
            leds <= lamp(seq[step_n]);
          end
        end else cnt <= cnt + CW'(1);
        WAIT_IN: begin
          leds <= '0;
          if (edge_r == '0) begin
            cnt <= timed_out ? '0 : cnt + CW'(1);
            if (timed_out) begin
              state <= LOSE;
              lose <= 1'b1;
            end
          end else if (edge_r == lamp(seq[step])) begin
            leds <= edge_r;
            cnt <= '0;
            if (last_step) state <= NEXT_LVL;
            else step <= step_n;
          end else begin
            state <= LOSE;
            cnt <= '0;
            lose <= 1'b1;
          end
        end
        NEXT_LVL: begin
          cnt <= '0;
          if (level == LW'(MAX_LEN - 1)) begin
            state <= WIN;
            leds <= '0;
            win <= 1'b1;
          end else begin
            state <= SHOW;
            level <= level + LW'(1);
            step <= '0;
            symbol_out <= seq[0];
            symbol_valid <= 1'b1;
            leds <= lamp(seq[0]);
          end
        end
        WIN, LOSE: begin
          state <= IDLE;
          busy <= 1'b0;
          leds <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_genius_seq_engine.sv
// tb_genius_seq_engine: randomized self-checking bench against a game-level reference model
module tb_genius_seq_engine;
  localparam int N = 3, ML = 4, SC = 2, TO = 8;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0;
  logic [2:0] btn = 3'b0, leds;
  logic [1:0] symbol_out, level, step;
  logic symbol_valid, busy, win, lose;
  logic [15:0] mq;
  int g [ML];
  int vectors = 0, errors = 0;

  genius_seq_engine #(.N_BTN(N), .MAX_LEN(ML), .SHOW_CYCLES(SC), .TIMEOUT_CYCLES(TO), .SEED(SEED)) dut (
    .clock(clock), .reset(reset), .start(start), .btn(btn), .leds(leds), .symbol_out(symbol_out),
    .symbol_valid(symbol_valid), .level(level), .step(step), .busy(busy), .win(win), .lose(lose));

  always #5 clock = ~clock;
  // model of the free-running LFSR so the expected sequence follows from the start cycle
  always @(posedge clock) mq <= !reset ? SEED : {mq[14:0], mq[15] ^ mq[13] ^ mq[12] ^ mq[10]};

  function automatic logic [2:0] lamp(input int s);
    return 3'(1 << s);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) reset = 1'b1;
      @(negedge clock);
      vectors++; if ({leds, symbol_out, symbol_valid, level, step, busy, win, lose} !== 13'b0) begin errors++; $display("FAIL reset_outputs cycle=%0d got=%b exp=0", c, {leds, symbol_out, symbol_valid, level, step, busy, win, lose}); end
    end
  endtask

  task automatic do_start();
    repeat ($urandom_range(0, 5)) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    vectors++; if (busy !== 1'b1 || level !== 2'd0 || step !== 2'd0) begin errors++; $display("FAIL start_busy got busy=%b level=%0d step=%0d exp 1/0/0", busy, level, step); end
    g[0] = int'(mq[1:0]) % N;
    for (int k = 1; k < ML; k++) begin
      @(negedge clock);
      g[k] = int'(mq[1:0]) % N;
      vectors++; if (symbol_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL gen_quiet k=%0d got valid=%b busy=%b exp 0/1", k, symbol_valid, busy); end
    end
  endtask

  task automatic play(input int lv);
    for (int k = 0; k <= lv; k++)
      for (int c = 0; c < 2 * SC; c++) begin
        @(negedge clock);
        if (c < SC) begin
          vectors++; if (symbol_valid !== 1'b1 || symbol_out !== 2'(g[k]) || leds !== lamp(g[k]) || step !== 2'(k) || level !== 2'(lv)) begin errors++; $display("FAIL show lv=%0d k=%0d got valid=%b sym=%0d leds=%b step=%0d level=%0d exp sym=%0d leds=%b", lv, k, symbol_valid, symbol_out, leds, step, level, g[k], lamp(g[k])); end
        end else begin
          vectors++; if (symbol_valid !== 1'b0 || leds !== 3'b0 || step !== 2'(k)) begin errors++; $display("FAIL gap lv=%0d k=%0d got valid=%b leds=%b step=%0d exp 0/000/%0d", lv, k, symbol_valid, leds, step, k); end
        end
      end
  endtask

  task automatic press(input int k, input int lv, input logic [2:0] b);
    @(negedge clock);
    btn = b;
    vectors++; if (leds !== 3'b0 || lose !== 1'b0) begin errors++; $display("FAIL wait_idle k=%0d got leds=%b lose=%b exp 000/0", k, leds, lose); end
    @(negedge clock);
    btn = 3'b0;
    @(negedge clock);
    vectors++; if (leds !== b || lose !== 1'b0 || win !== 1'b0 || step !== 2'(k < lv ? k + 1 : lv)) begin errors++; $display("FAIL press lv=%0d k=%0d got leds=%b lose=%b win=%b step=%0d exp leds=%b step=%0d", lv, k, leds, lose, win, step, b, k < lv ? k + 1 : lv); end
  endtask

  task automatic bad_press(input logic [2:0] b, input int lv);
    @(negedge clock);
    btn = b;
    @(negedge clock);
    btn = 3'b0;
    vectors++; if (lose !== 1'b0) begin errors++; $display("FAIL bad_early got lose=%b exp 0", lose); end
    @(negedge clock);
    vectors++; if (lose !== 1'b1 || busy !== 1'b1 || level !== 2'(lv)) begin errors++; $display("FAIL bad_lose got lose=%b busy=%b level=%0d exp 1/1/%0d", lose, busy, level, lv); end
    @(negedge clock);
    vectors++; if (lose !== 1'b0 || busy !== 1'b0 || level !== 2'(lv)) begin errors++; $display("FAIL bad_idle got lose=%b busy=%b level=%0d exp 0/0/%0d", lose, busy, level, lv); end
  endtask

  task automatic expect_timeout();
    for (int w = 0; w < TO; w++) begin
      @(negedge clock);
      vectors++; if (lose !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_early w=%0d got lose=%b busy=%b exp 0/1", w, lose, busy); end
    end
    @(negedge clock);
    vectors++; if (lose !== 1'b1) begin errors++; $display("FAIL timeout_lose got lose=%b exp 1", lose); end
    @(negedge clock);
    vectors++; if (lose !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_idle got lose=%b busy=%b exp 0/0", lose, busy); end
  endtask

  task automatic test_full_game();
    do_start();
    for (int lv = 0; lv < ML; lv++) begin
      play(lv);
      for (int k = 0; k <= lv; k++) press(k, lv, lamp(g[k]));
    end
    @(negedge clock);
    vectors++; if (win !== 1'b1 || lose !== 1'b0 || busy !== 1'b1 || level !== 2'(ML - 1)) begin errors++; $display("FAIL win_pulse got win=%b lose=%b busy=%b level=%0d exp 1/0/1/%0d", win, lose, busy, level, ML - 1); end
    @(negedge clock);
    vectors++; if (win !== 1'b0 || busy !== 1'b0 || level !== 2'(ML - 1)) begin errors++; $display("FAIL win_idle got win=%b busy=%b level=%0d exp 0/0/%0d", win, busy, level, ML - 1); end
  endtask

  task automatic test_wrong_press();
    do_start();
    play(0);
    press(0, 0, lamp(g[0]));
    play(1);
    bad_press(lamp((g[0] + 1 + int'($urandom_range(0, 1))) % N), 1);
  endtask

  task automatic test_timeout();
    btn = 3'($urandom_range(1, 7));
    do_start();
    play(0);
    expect_timeout();
    btn = 3'b0;
  endtask

  task automatic test_double();
    logic [2:0] pairs [3];
    pairs = '{3'b011, 3'b101, 3'b110};
    do_start();
    play(0);
    bad_press(pairs[$urandom_range(0, 2)], 0);
  endtask

  task automatic test_reset_mid();
    do_start();
    @(negedge clock);
    vectors++; if (symbol_valid !== 1'b1) begin errors++; $display("FAIL first_show got valid=%b exp 1", symbol_valid); end
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    vectors++; if ({leds, symbol_valid, level, step, busy} !== 9'b0) begin errors++; $display("FAIL reset_mid got=%b exp 0", {leds, symbol_valid, level, step, busy}); end
    do_start();
    play(0);
    press(0, 0, lamp(g[0]));
    play(1);
    expect_timeout();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    test_reset();
    repeat (3) test_full_game();
    test_wrong_press();
    test_timeout();
    test_double();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
